alarm_buzzer_ctrl: RTL and testbench
====================================

// Module: alarm_buzzer_ctrl
// PURPOSE
//  Downstream consumer of the digital clock's BCD time word (mm:ss) and 1 s tick.
//  - Compares the running time against a programmed alarm time.
//  - Runs a ring/snooze/stop state machine.
//  - Drives the board BUZZER with a gated square-wave tone.
//  - Replaces the ad-hoc buzzer logic with a fully synchronous, single-clock block.
// PARAMETERS
//  TONE_DIV     25000  tone half-period in CLK cycles (>=2)
//  RING_SECS    30     ticks the alarm rings before auto-stop (>=1)
//  SNOOZE_SECS  60     ticks spent in SNOOZE before re-ringing (>=1)
// PORTS
//  CLK          in   1   system clock; the only clock
//  rst          in   1   synchronous, active-low reset
//  tick_1s      in   1   one-CLK strobe, asserted in the cycle time_bcd updates
//  time_bcd     in   16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
//  alarm_bcd    in   16  alarm time, same packing as time_bcd
//  alarm_en     in   1   level; 0 disarms the alarm and forces IDLE
//  stop_btn     in   1   debounced level; acts on its rising edge
//  snooze_btn   in   1   debounced level; acts on its rising edge
//  BUZZER       out  1   buzzer drive
//  alarm_active out  1   1 while state != IDLE
//  state        out  2   00 IDLE, 01 RING, 10 SNOOZE (11 never occurs)
// BEHAVIOUR
//  - Reset values (rst=0 at a posedge):
//    - state=IDLE; BUZZER=0; alarm_active=0.
//    - All counters=0; tone=0; gate=0; button edge registers=0.
//  - Button edges: stop_q and snooze_q register the inputs.
//    - Edge = btn & ~btn_q.
//    - A held level acts once.
//    - An edge present during reset is not acted on.
//  - Alarm match: evaluated only in a cycle with tick_1s=1.
//    - Requires alarm_en=1 and time_bcd==alarm_bcd.
//    - Requires alarm_bcd digits valid: sec_ones<=9, sec_tens<=5, min_ones<=9, min_tens<=5.
//    - An invalid alarm_bcd never matches.
//  - Transitions, highest priority first; state updates at the next posedge:
//    1. alarm_en=0 -> IDLE from any state.
//    2. stop edge in RING or SNOOZE -> IDLE.
//    3. snooze edge in RING -> SNOOZE; snooze_cnt cleared.
//    4. RING: ring_cnt counts tick_1s; on the tick where ring_cnt reaches RING_SECS -> IDLE.
//    5. SNOOZE: snooze_cnt counts tick_1s; on reaching SNOOZE_SECS -> RING.
//       ring_cnt cleared; tone and gate reloaded.
//    6. IDLE: match -> RING.
//       ring_cnt=0, tone_cnt=0, tone=1, gate=1.
//  - Match in RING or SNOOZE is ignored; no retrigger.
//  - Stop or snooze edges in IDLE are ignored.
//  - Latency:
//    - Match tick at cycle N -> state=RING and BUZZER=1 at N+1.
//    - The matching tick does not count toward ring_cnt.
//  - Tone:
//    - In RING, tone_cnt counts 0..TONE_DIV-1.
//    - At TONE_DIV-1 it wraps to 0 and tone toggles.
//  - Gate: toggles on every tick_1s in RING, giving 1 s beep / 1 s silence.
//  - Outputs:
//    - BUZZER = tone & gate & (state==RING), built only from registers.
//    - BUZZER=0 in IDLE and SNOOZE.
//  - Counter widths: $clog2(param+1); no overflow is possible.
//  - Reset mid-ring: BUZZER=0 and state=IDLE at the first posedge with rst=0.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined:
//    - snooze_btn is honoured; the SNOOZE state exists as described.
//  ALARM_SNOOZE_EN undefined:
//    - snooze_btn is ignored; the port remains for pin compatibility.
//    - The SNOOZE logic and snooze_cnt are not built.
//    - state never equals 10.
// TESTING  (TONE_DIV=4, RING_SECS=3, SNOOZE_SECS=2)
//  - rst=0 for 2 cycles with random inputs -> BUZZER=0, state=00, alarm_active=0.
//  - alarm_bcd=16'h0105, alarm_en=1; time 0104 -> 0105 with tick ->
//    state=01 next cycle; BUZZER toggles every 4 CLKs; silent after the next tick.
//  - Ring with no buttons -> state=00 one cycle after the 3rd tick following entry.
//  - stop_btn held high 10 cycles during RING -> IDLE one cycle after the rising edge.
//    Then alarm_en=0 with time=0105 and tick -> no ring.
//  - Snooze edge in RING:
//    - Macro on -> state=10, BUZZER=0; after 2 ticks state=01.
//    - Macro off -> state stays 01.
//  - alarm_bcd=16'h0170 (sec_tens=7) with time 0170 and tick -> stays IDLE.
//    rst=0 mid-ring -> BUZZER=0 at the next edge.

Source files
------------

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm comparator, ring/snooze/stop state machine and gated buzzer tone.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_buzzer_ctrl #(
   parameter int TONE_DIV    = 25000,
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_SECS = 60
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        tick_1s,
   input  logic [15:0] time_bcd,
   input  logic [15:0] alarm_bcd,
   input  logic        alarm_en,
   input  logic        stop_btn,
   input  logic        snooze_btn,
   output logic        BUZZER,
   output logic        alarm_active,
   output logic [1:0]  state
);

   localparam int TW = $clog2(TONE_DIV + 1);
   localparam int RW = $clog2(RING_SECS + 1);
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RING   = 2'b01,
      SNOOZE = 2'b10
   } state_t;

   state_t        st;
   logic [TW-1:0] tone_cnt;
   logic [RW-1:0] ring_cnt;
   logic          tone;
   logic          gate;
   logic          stop_q;
   logic          stop_edge;
   logic          digits_ok;
   logic          match;

`ifdef ALARM_SNOOZE_EN
   localparam int SW = $clog2(SNOOZE_SECS + 1);
   localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);
   logic          snooze_q;
   logic          snooze_edge;
   logic [SW-1:0] snooze_cnt;
   assign snooze_edge = snooze_btn & ~snooze_q;
`else
   // Snooze pin is kept for board compatibility but has no effect here.
   logic unused_snooze;
   assign unused_snooze = snooze_btn & (SNOOZE_SECS >= 1);
`endif

   assign stop_edge = stop_btn & ~stop_q;
   assign digits_ok = (alarm_bcd[3:0] <= 4'd9) && (alarm_bcd[7:4] <= 4'd5) &&
                      (alarm_bcd[11:8] <= 4'd9) && (alarm_bcd[15:12] <= 4'd5);
   assign match     = alarm_en && (time_bcd == alarm_bcd) && digits_ok;

   assign state        = st;
   assign alarm_active = (st != IDLE);
   assign BUZZER       = tone & gate & (st == RING);

   always_ff @(posedge CLK) begin
      if (!rst) begin
         st       <= IDLE;
         tone_cnt <= '0;
         ring_cnt <= '0;
         tone     <= 1'b0;
         gate     <= 1'b0;
         stop_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snooze_q   <= 1'b0;
         snooze_cnt <= '0;
`endif
      end else begin
         stop_q <= stop_btn;
`ifdef ALARM_SNOOZE_EN
         snooze_q <= snooze_btn;
`endif
         if (!alarm_en) begin
            st <= IDLE;
         end else if (stop_edge && st != IDLE) begin
            st <= IDLE;
`ifdef ALARM_SNOOZE_EN
         end else if (snooze_edge && st == RING) begin
            st         <= SNOOZE;
            snooze_cnt <= '0;
`endif
         end else begin
            case (st)
               RING: begin
                  if (tone_cnt == TONE_LAST) begin
                     tone_cnt <= '0;
                     tone     <= ~tone;
                  end else begin
                     tone_cnt <= tone_cnt + 1'b1;
                  end
                  // The tick that completes the ring period ends it instead of toggling the gate.
                  if (tick_1s) begin
                     ring_cnt <= ring_cnt + 1'b1;
                     if (ring_cnt == RING_LAST) st <= IDLE;
                     else                       gate <= ~gate;
                  end
               end
               SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                  if (tick_1s) begin
                     snooze_cnt <= snooze_cnt + 1'b1;
                     if (snooze_cnt == SNOOZE_LAST) begin
                        st       <= RING;
                        ring_cnt <= '0;
                        tone_cnt <= '0;
                        tone     <= 1'b1;
                        gate     <= 1'b1;
                     end
                  end
`else
                  st <= IDLE;
`endif
               end
               default: begin
                  if (tick_1s && match) begin
                     st       <= RING;
                     ring_cnt <= '0;
                     tone_cnt <= '0;
                     tone     <= 1'b1;
                     gate     <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Randomized and directed bench for alarm_buzzer_ctrl with a per-cycle scoreboard.
module tb_alarm_buzzer_ctrl;

   localparam int TONE_DIV    = 4;
   localparam int RING_SECS   = 3;
   localparam int SNOOZE_SECS = 2;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic        tick_1s = 1'b0;
   logic [15:0] time_bcd = 16'h0000;
   logic [15:0] alarm_bcd = 16'h0000;
   logic        alarm_en = 1'b0;
   logic        stop_btn = 1'b0;
   logic        snooze_btn = 1'b0;
   logic        BUZZER;
   logic        alarm_active;
   logic [1:0]  state;

   logic [3:0] exp_q[$];
   logic [3:0] mon_e;
   int checks = 0;
   int errors = 0;

   int   m_state  = 0;
   int   m_cyc    = 0;
   int   m_rticks = 0;
   int   m_sticks = 0;
   logic m_pstop  = 1'b0;
   logic m_psnz   = 1'b0;
   bit   snooze_on;

   alarm_buzzer_ctrl #(
      .TONE_DIV(TONE_DIV), .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)
   ) dut (
      .CLK(CLK), .rst(rst), .tick_1s(tick_1s), .time_bcd(time_bcd),
      .alarm_bcd(alarm_bcd), .alarm_en(alarm_en), .stop_btn(stop_btn),
      .snooze_btn(snooze_btn), .BUZZER(BUZZER), .alarm_active(alarm_active),
      .state(state)
   );

   initial forever #5 CLK = ~CLK;

   function automatic bit alarm_hits(input logic [15:0] t, input logic [15:0] a);
      int v;
      v = int'(a);
      return (t == a) && (v % 16 <= 9) && ((v / 16) % 16 <= 5) &&
             ((v / 256) % 16 <= 9) && (v / 4096 <= 5);
   endfunction

   // Reference: what the outputs must be after the coming clock edge.
   task automatic model_step();
      bit stop_e, snz_e, buz;
      if (!rst) begin
         m_state = 0;
         m_pstop = 1'b0;
         m_psnz  = 1'b0;
      end else begin
         stop_e  = stop_btn && !m_pstop;
         snz_e   = snooze_on && snooze_btn && !m_psnz;
         m_pstop = stop_btn;
         m_psnz  = snooze_btn;
         if (!alarm_en) m_state = 0;
         else if (stop_e && m_state != 0) m_state = 0;
         else if (snz_e && m_state == 1) begin
            m_state  = 2;
            m_sticks = 0;
         end else if (m_state == 1) begin
            m_cyc++;
            if (tick_1s) begin
               m_rticks++;
               if (m_rticks == RING_SECS) m_state = 0;
            end
         end else if (m_state == 2) begin
            if (tick_1s) begin
               m_sticks++;
               if (m_sticks == SNOOZE_SECS) begin
                  m_state  = 1;
                  m_cyc    = 0;
                  m_rticks = 0;
               end
            end
         end else if (tick_1s && alarm_hits(time_bcd, alarm_bcd)) begin
            m_state  = 1;
            m_cyc    = 0;
            m_rticks = 0;
         end
      end
      buz = (m_state == 1) && ((m_cyc / TONE_DIV) % 2 == 0) && (m_rticks % 2 == 0);
      exp_q.push_back({2'(m_state), buz, m_state != 0});
   endtask

   task automatic drive(input logic r, input logic t, input logic [15:0] tm,
                        input logic e, input logic sp, input logic sz);
      @(negedge CLK);
      rst        = r;
      tick_1s    = t;
      time_bcd   = tm;
      alarm_en   = e;
      stop_btn   = sp;
      snooze_btn = sz;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, time_bcd, alarm_en, stop_btn, snooze_btn);
   endtask

   task automatic run_ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         idle(gap - 1);
         drive(1'b1, 1'b1, 16'h0200 + 16'(i), alarm_en, stop_btn, snooze_btn);
      end
   endtask

   task automatic ring_up();
      drive(1'b1, 1'b0, 16'h0104, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, alarm_bcd, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are registered, so sample just after each active edge.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({state, BUZZER, alarm_active} !== mon_e) begin
               errors++;
               $display("FAIL outputs t=%0t state/buzzer/active got %b/%b/%b expected %b/%b/%b",
                        $time, state, BUZZER, alarm_active, mon_e[3:2], mon_e[1], mon_e[0]);
            end
         end
      end
   end

   initial begin
`ifdef ALARM_SNOOZE_EN
      snooze_on = 1'b1;
`else
      snooze_on = 1'b0;
`endif
      for (int i = 0; i < 2; i++)
         drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

      alarm_bcd = 16'h0105;
      ring_up();
      idle(17);
      run_ticks(RING_SECS, 6);
      idle(4);

      ring_up();
      idle(3);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 16'h0105, 1'b0, 1'b0, 1'b0);
      idle(3);
      drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b0, 1'b0);

      ring_up();
      idle(2);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b0, 1'b0);
      run_ticks(SNOOZE_SECS + 1, 5);
      drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b0, 1'b0);
      idle(2);

      alarm_bcd = 16'h0170;
      drive(1'b1, 1'b1, 16'h0170, 1'b1, 1'b0, 1'b0);
      idle(3);

      alarm_bcd = 16'h0105;
      ring_up();
      idle(2);
      drive(1'b0, 1'b0, 16'h0106, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 16'h0106, 1'b1, 1'b0, 1'b0);
      idle(2);

      for (int blk = 0; blk < 6; blk++) begin
         case (blk % 4)
            0: alarm_bcd = 16'h0105;
            1: alarm_bcd = 16'h0059;
            2: alarm_bcd = 16'h0170;
            default: alarm_bcd = 16'($urandom);
         endcase
         for (int i = 0; i < 500; i++)
            drive($urandom_range(0, 199) != 0,
                  $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 2) == 0) ? alarm_bcd : 16'($urandom),
                  $urandom_range(0, 19) != 0,
                  ($urandom_range(0, 14) == 0) ? ~stop_btn : stop_btn,
                  ($urandom_range(0, 9) == 0) ? ~snooze_btn : snooze_btn);
      end

      repeat (2) @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
